// File: rtl/alu_cmd_ctrl_if.sv
// Command/ALU/response bundle between alu_cmd_ctrl and its environment.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; optional rsp_zero under ALU_CMD_CTRL_ZFLAG_EN.
interface alu_cmd_ctrl_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ld;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  // external ALU
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [1:0] alu_op;
  logic [3:0] alu_res;
  logic       alu_Cout;
  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_res;
  logic       rsp_cout;
`ifdef ALU_CMD_CTRL_ZFLAG_EN
  logic       rsp_zero;
`endif
  // status
  logic [3:0] acc;
  logic       busy;

  // controller side
  modport slave (
    input  cmd_valid, cmd_ld, cmd_op, cmd_data, alu_res, alu_Cout, rsp_ready,
    output cmd_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_res, rsp_cout,
`ifdef ALU_CMD_CTRL_ZFLAG_EN
    output rsp_zero,
`endif
    output acc, busy
  );

  // environment side (command source, ALU, response sink)
  modport master (
    output cmd_valid, cmd_ld, cmd_op, cmd_data, alu_res, alu_Cout, rsp_ready,
    input  cmd_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_res, rsp_cout,
`ifdef ALU_CMD_CTRL_ZFLAG_EN
    input  rsp_zero,
`endif
    input  acc, busy
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Accumulator controller: loads acc or issues acc op data to an external ALU; optional zero flag via ALU_CMD_CTRL_ZFLAG_EN.
// Latency: load responds 1 edge after accept, ALU op LAT edges after accept; one command per LAT+2 cycles at best.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_valid & rsp_ready.
module alu_cmd_ctrl #(
  parameter int unsigned LAT = 1   // ALU settle cycles, 1..7
) (
  input  logic          clock,
  input  logic          reset,
  alu_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LatCnt = 3'(LAT);

  state_t     stateQ;
  state_t     stateD;
  logic [2:0] cntQ;
  logic [3:0] accQ;
  logic [3:0] aluAQ;
  logic [3:0] aluBQ;
  logic [1:0] aluOpQ;
  logic [3:0] rspResQ;
  logic       rspCoutQ;

  logic accept;
  logic capture;
  logic rspDone;

  // cmd_valid outside IDLE is simply not looked at
  assign accept  = bus.cmd_valid && (stateQ == IDLE);
  // counter reaching 1 in WAIT marks the LAT-th edge after accept
  assign capture = (stateQ == WAIT) && (cntQ == 3'd1);
  assign rspDone = (stateQ == RESP) && bus.rsp_ready;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // next-state: a handshake edge returns to IDLE only, so no back-to-back accept
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (accept) stateD = bus.cmd_ld ? RESP : WAIT;
      WAIT: if (capture) stateD = RESP;
      RESP: if (rspDone) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.cmd_ready = (stateQ == IDLE);
    bus.rsp_valid = (stateQ == RESP);
    bus.busy      = (stateQ != IDLE);
  end

  // settle counter: loaded on ALU issue, counts down through WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cntQ <= 3'd0;
    end else if (accept && !bus.cmd_ld) begin
      cntQ <= LatCnt;
    end else if (stateQ == WAIT) begin
      cntQ <= cntQ - 3'd1;
    end
  end

  // ALU operand registers: only a non-load accept changes them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluAQ  <= 4'd0;
      aluBQ  <= 4'd0;
      aluOpQ <= 2'b00;
    end else if (accept && !bus.cmd_ld) begin
      aluAQ  <= accQ;
      aluBQ  <= bus.cmd_data;
      aluOpQ <= bus.cmd_op;
    end
  end

  // accumulator and response: written on load accept or ALU capture, otherwise held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accQ     <= 4'd0;
      rspResQ  <= 4'd0;
      rspCoutQ <= 1'b0;
    end else if (accept && bus.cmd_ld) begin
      accQ     <= bus.cmd_data;
      rspResQ  <= bus.cmd_data;
      rspCoutQ <= 1'b0;
    end else if (capture) begin
      accQ     <= bus.alu_res;
      rspResQ  <= bus.alu_res;
      // logic ops have no meaningful carry, whatever the ALU drives
      rspCoutQ <= aluOpQ[1] ? 1'b0 : bus.alu_Cout;
    end
  end

`ifdef ALU_CMD_CTRL_ZFLAG_EN
  logic rspZeroQ;

  // zero flag tracks the same write events as rsp_res
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rspZeroQ <= 1'b0;
    end else if (accept && bus.cmd_ld) begin
      rspZeroQ <= (bus.cmd_data == 4'd0);
    end else if (capture) begin
      rspZeroQ <= (bus.alu_res == 4'd0);
    end
  end

  assign bus.rsp_zero = rspZeroQ;
`endif

  assign bus.acc      = accQ;
  assign bus.alu_A    = aluAQ;
  assign bus.alu_B    = aluBQ;
  assign bus.alu_op   = aluOpQ;
  assign bus.rsp_res  = rspResQ;
  assign bus.rsp_cout = rspCoutQ;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: LAT=1 and LAT=3 instances behind a behavioural ALU, vector table plus corner sequences.
// Latency: checks response edge count against LAT for each command.
// Backpressure: holds rsp_ready low with a pending command to check hold and non-acceptance.
module tb_alu_cmd_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset1;
  logic       reset3;
  logic       sel;        // 0 -> LAT=1 instance, 1 -> LAT=3 instance
  logic       cmdValid;
  logic       cmdLd;
  logic [1:0] cmdOp;
  logic [3:0] cmdData;
  logic       rspReady;
  logic       forceCout;

  alu_cmd_ctrl_if bus1 ();
  alu_cmd_ctrl_if bus3 ();

  alu_cmd_ctrl #(.LAT(1)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));
  alu_cmd_ctrl #(.LAT(3)) dut3 (.clock(clock), .reset(reset3), .bus(bus3));

  // behavioural ALU: {cout, res}; sub cout is no-borrow, logic ops drive forceCout
  function automatic logic [4:0] aluFn(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op, input logic fc);
    case (op)
      2'b00:   aluFn = {1'b0, a} + {1'b0, b};
      2'b01:   aluFn = {(a >= b), 4'(a - b)};
      2'b10:   aluFn = {fc, a & b};
      default: aluFn = {fc, a | b};
    endcase
  endfunction

  assign bus1.cmd_valid = cmdValid & ~sel;
  assign bus3.cmd_valid = cmdValid & sel;
  assign bus1.cmd_ld    = cmdLd;
  assign bus3.cmd_ld    = cmdLd;
  assign bus1.cmd_op    = cmdOp;
  assign bus3.cmd_op    = cmdOp;
  assign bus1.cmd_data  = cmdData;
  assign bus3.cmd_data  = cmdData;
  assign bus1.rsp_ready = rspReady & ~sel;
  assign bus3.rsp_ready = rspReady & sel;
  assign {bus1.alu_Cout, bus1.alu_res} = aluFn(bus1.alu_A, bus1.alu_B, bus1.alu_op, forceCout);
  assign {bus3.alu_Cout, bus3.alu_res} = aluFn(bus3.alu_A, bus3.alu_B, bus3.alu_op, forceCout);

  // observed outputs of the selected instance
  logic       obsReady, obsValid, obsCout, obsBusy;
  logic [3:0] obsRes, obsAcc, obsA, obsB;
  logic [1:0] obsOp;
  assign obsReady = sel ? bus3.cmd_ready : bus1.cmd_ready;
  assign obsValid = sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign obsCout  = sel ? bus3.rsp_cout  : bus1.rsp_cout;
  assign obsBusy  = sel ? bus3.busy      : bus1.busy;
  assign obsRes   = sel ? bus3.rsp_res   : bus1.rsp_res;
  assign obsAcc   = sel ? bus3.acc       : bus1.acc;
  assign obsA     = sel ? bus3.alu_A     : bus1.alu_A;
  assign obsB     = sel ? bus3.alu_B     : bus1.alu_B;
  assign obsOp    = sel ? bus3.alu_op    : bus1.alu_op;
`ifdef ALU_CMD_CTRL_ZFLAG_EN
  logic obsZero;
  assign obsZero = sel ? bus3.rsp_zero : bus1.rsp_zero;
`endif

  typedef struct {
    logic       ld;
    logic [1:0] op;
    logic [3:0] data;
    logic       fc;
    logic [3:0] expRes;   // also the expected accumulator
    logic       expCout;
  } vec_t;

  vec_t vecs [10];

  int nChecks = 0;
  int nPass   = 0;

  logic [3:0] lastA, lastB, lastAcc;
  logic [1:0] lastOp;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (sel=%0d, t=%0t)", name, act, exp, sel, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic runVec(input vec_t v, input int lat);
    int edges;
    check("cmd_ready idle", 8'(obsReady), 8'd1);
    cmdValid  = 1'b1;
    cmdLd     = v.ld;
    cmdOp     = v.op;
    cmdData   = v.data;
    forceCout = v.fc;
    tick();
    cmdValid = 1'b0;
    if (!v.ld) begin
      lastA  = lastAcc;
      lastB  = v.data;
      lastOp = v.op;
    end
    check("alu_A", 8'(obsA), 8'(lastA));
    check("alu_B", 8'(obsB), 8'(lastB));
    check("alu_op", 8'(obsOp), 8'(lastOp));
    edges = 0;
    while (!obsValid && edges < 20) begin
      tick();
      edges++;
    end
    check("edges to rsp_valid", 8'(edges), v.ld ? 8'd0 : 8'(lat));
    check("rsp_res", 8'(obsRes), 8'(v.expRes));
    check("rsp_cout", 8'(obsCout), 8'(v.expCout));
    check("acc", 8'(obsAcc), 8'(v.expRes));
`ifdef ALU_CMD_CTRL_ZFLAG_EN
    check("rsp_zero", 8'(obsZero), 8'(v.expRes == 4'd0));
`endif
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check("rsp_valid after handshake", 8'(obsValid), 8'd0);
    check("busy after handshake", 8'(obsBusy), 8'd0);
    lastAcc = v.expRes;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sawValid;
    //           ld    op     data   fc    res    cout
    vecs[0] = '{1'b1, 2'b00, 4'h5, 1'b0, 4'h5, 1'b0};  // load 5
    vecs[1] = '{1'b0, 2'b00, 4'hC, 1'b0, 4'h1, 1'b1};  // 5+C
    vecs[2] = '{1'b0, 2'b01, 4'h3, 1'b0, 4'hE, 1'b0};  // 1-3, borrow
    vecs[3] = '{1'b0, 2'b10, 4'h6, 1'b1, 4'h6, 1'b0};  // E&6, carry forced high
    vecs[4] = '{1'b0, 2'b11, 4'h9, 1'b1, 4'hF, 1'b0};  // 6|9
    vecs[5] = '{1'b0, 2'b00, 4'h1, 1'b0, 4'h0, 1'b1};  // F+1 wraps
    vecs[6] = '{1'b0, 2'b01, 4'h0, 1'b0, 4'h0, 1'b1};  // 0-0, no borrow
    vecs[7] = '{1'b1, 2'b00, 4'hA, 1'b0, 4'hA, 1'b0};  // load A
    vecs[8] = '{1'b0, 2'b01, 4'hB, 1'b0, 4'hF, 1'b0};  // A-B
    vecs[9] = '{1'b0, 2'b10, 4'h0, 1'b1, 4'h0, 1'b0};  // F&0

    sel       = 1'b0;
    cmdValid  = 1'b0;
    cmdLd     = 1'b0;
    cmdOp     = 2'b00;
    cmdData   = 4'h0;
    rspReady  = 1'b0;
    forceCout = 1'b0;
    reset1    = 1'b1;
    reset3    = 1'b1;
    tick();
    tick();
    reset1 = 1'b0;
    reset3 = 1'b0;
    tick();

    // reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset cmd_ready", 8'(obsReady), 8'd1);
      check("reset rsp_valid", 8'(obsValid), 8'd0);
      check("reset busy", 8'(obsBusy), 8'd0);
      check("reset acc", 8'(obsAcc), 8'd0);
      check("reset rsp_res", 8'(obsRes), 8'd0);
      check("reset alu_A", 8'(obsA), 8'd0);
    end

    // vector table on LAT=1
    sel = 1'b0;
    lastA = 4'h0; lastB = 4'h0; lastOp = 2'b00; lastAcc = 4'h0;
    for (int i = 0; i < 10; i++) runVec(vecs[i], 1);

    // backpressure: response held, second command offered but not taken
    cmdValid = 1'b1; cmdLd = 1'b1; cmdData = 4'h7;
    tick();
    cmdData = 4'h3;
    for (int i = 0; i < 3; i++) begin
      check("bp rsp_valid", 8'(obsValid), 8'd1);
      check("bp rsp_res held", 8'(obsRes), 8'h7);
      check("bp cmd_ready", 8'(obsReady), 8'd0);
      tick();
    end
    check("bp acc unchanged", 8'(obsAcc), 8'h7);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check("bp handshake edge rsp_valid", 8'(obsValid), 8'd0);
    check("bp handshake edge cmd_ready", 8'(obsReady), 8'd1);
    check("bp no accept on handshake", 8'(obsAcc), 8'h7);
    tick();
    cmdValid = 1'b0;
    check("bp next accept rsp_valid", 8'(obsValid), 8'd1);
    check("bp next accept rsp_res", 8'(obsRes), 8'h3);
    check("bp next accept acc", 8'(obsAcc), 8'h3);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // vector table on LAT=3
    sel = 1'b1;
    #1;
    lastA = 4'h0; lastB = 4'h0; lastOp = 2'b00; lastAcc = 4'h0;
    for (int i = 0; i < 10; i++) runVec(vecs[i], 3);

    // reset mid-WAIT on LAT=3: load 9, then issue add and reset during the count
    runVec('{1'b1, 2'b00, 4'h9, 1'b0, 4'h9, 1'b0}, 3);
    cmdValid = 1'b1; cmdLd = 1'b0; cmdOp = 2'b00; cmdData = 4'h1;
    tick();
    cmdValid = 1'b0;
    tick();
    check("wait busy", 8'(obsBusy), 8'd1);
    check("wait no rsp", 8'(obsValid), 8'd0);
    reset3 = 1'b1;
    #1;
    check("rst acc", 8'(obsAcc), 8'd0);
    check("rst alu_A", 8'(obsA), 8'd0);
    check("rst alu_B", 8'(obsB), 8'd0);
    check("rst rsp_res", 8'(obsRes), 8'd0);
    check("rst busy", 8'(obsBusy), 8'd0);
    check("rst rsp_valid", 8'(obsValid), 8'd0);
    tick();
    reset3 = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obsValid) sawValid = 1'b1;
    end
    check("no rsp after reset", 8'(sawValid), 8'd0);
    check("cmd_ready after reset", 8'(obsReady), 8'd1);
    check("acc after reset", 8'(obsAcc), 8'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning ALU settle cycles between operand issue and result capture; legal range 1..7.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  controller can accept a command.
REQ-006 SHALL have port cmd_ld  in  1  1 = load accumulator with cmd_data; 0 = ALU operation.
REQ-007 SHALL have port cmd_op  in  2  ALU op code: 00 add, 01 sub, 10 and, 11 or.
REQ-008 SHALL have port cmd_data  in  4  operand B, or load value.
REQ-009 SHALL have port alu_A  out  4  operand A to the external ALU.
REQ-010 SHALL have port alu_B  out  4  operand B to the external ALU.
REQ-011 SHALL have port alu_op  out  2  op code to the external ALU.
REQ-012 SHALL have port alu_res  in  4  ALU result.
REQ-013 SHALL have port alu_Cout  in  1  ALU carry-out (carry for add, no-borrow for sub).
REQ-014 SHALL have port rsp_valid  out  1  response available.
REQ-015 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-016 SHALL have port rsp_res  out  4  response result.
REQ-017 SHALL have port rsp_cout  out  1  response carry.
REQ-018 SHALL have port acc  out  4  current accumulator value.
REQ-019 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, RESP; cmd_ready = 1 only in IDLE.
REQ-021 Accept = cmd_valid & cmd_ready at a rising edge; cmd_valid outside IDLE SHALL be ignored.
REQ-022 On accept with cmd_ld=1: acc <= cmd_data, rsp_res <= cmd_data, rsp_cout <= 0, next state RESP; ALU ports unchanged.
REQ-023 On accept with cmd_ld=0: alu_A <= acc, alu_B <= cmd_data, alu_op <= cmd_op, wait counter <= LAT, next state WAIT.
REQ-024 In WAIT the counter SHALL decrement each edge; at the LAT-th edge after accept, rsp_res and acc SHALL both be set to alu_res, and state SHALL go to RESP.
REQ-025 At capture, rsp_cout <= alu_Cout when alu_op[1]=0, and 0 when alu_op[1]=1, regardless of alu_Cout.
REQ-026 rsp_valid SHALL be 1 exactly in RESP; rsp_res/rsp_cout SHALL be held stable until rsp_valid & rsp_ready.
REQ-027 On response handshake the next state SHALL be IDLE; no command is accepted in the same edge (max one command per LAT+2 cycles).
REQ-028 alu_A/alu_B/alu_op SHALL be registered outputs holding the last issued values until the next non-load accept.
REQ-029 Arithmetic SHALL be modulo 16; there is no internal arithmetic, and all results come from alu_res.

Reset
REQ-030 On reset: state IDLE, acc=0, alu_A=0, alu_B=0, alu_op=00, rsp_res=0, rsp_cout=0, rsp_valid=0, busy=0, counter=0.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the operation; no response is emitted and acc reverts to 0.

Configuration
REQ-032 With ALU_CMD_CTRL_ZFLAG_EN defined, the block SHALL add output rsp_zero (1 bit), registered alongside rsp_res, equal to (result == 0), reset 0, and held with the response.
REQ-033 Without ALU_CMD_CTRL_ZFLAG_EN, the block SHALL have no rsp_zero port and no zero-flag logic.

Verification (bench models the ALU behaviourally, LAT=1 and LAT=3)
REQ-034 Load: cmd_ld=1, cmd_data=0x5 -> one edge later rsp_valid=1, rsp_res=0x5, rsp_cout=0, acc=0x5, ALU ports unchanged.
REQ-035 Add: acc=0x5, cmd_op=00, cmd_data=0xC -> alu_A=0x5, alu_B=0xC, alu_op=00; after LAT edges rsp_res=0x1, rsp_cout=1, acc=0x1.
REQ-036 Sub: acc=0x1, cmd_op=01, cmd_data=0x3 -> rsp_res=0xE, rsp_cout=0, acc=0xE.
REQ-037 Logic: acc=0xE, cmd_op=10, cmd_data=0x6, ALU model forcing alu_Cout=1 -> rsp_res=0x6, rsp_cout=0; then cmd_op=11, cmd_data=0x9 -> rsp_res=0xF, rsp_cout=0.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles with cmd_valid=1 -> rsp_res stable, cmd_ready=0, no second command taken; accept occurs only the edge after the handshake.
REQ-039 Reset in WAIT (LAT=3, mid-count) -> all outputs zero immediately, rsp_valid never asserts, cmd_ready=1 after release.
